scoreboard_register_file: RTL and testbench

SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

---
 rtl/scoreboard_register_file.sv | 125 ++++++++++++
 tb/tb_scoreboard_register_file.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_register_file.sv
// rtl/scoreboard_register_file.sv - register file with per-register pending (busy) scoreboard
//
// Purpose: multi-port register file for an issue stage. A reservation marks a
// destination register pending; the writeback clears it. Reads are combinational.
// They can optionally see same-cycle writeback data through a bypass path.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   rd_addr/rd_data   NUM_READ packed read ports (combinational)
//   rd_ready          per read port: value is not pending
//   wr_en/wr_addr/wr_data/wr_be   writeback with byte enables; also clears busy
//   rsv_en/rsv_addr   reservation request; rsv_grant is the combinational accept
//   flush             clear every pending mark, data untouched
//   busy_count        registered popcount of pending registers
module scoreboard_register_file #(
  parameter int REG_NUM   = 32,
  parameter int REG_WIDTH = 32,
  parameter int NUM_READ  = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  localparam int ADDR_W   = $clog2(REG_NUM),
  localparam int BE_W     = REG_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_READ*ADDR_W-1:0]    rd_addr,
  output logic [NUM_READ*REG_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]           rd_ready,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [REG_WIDTH-1:0]          wr_data,
  input  logic [BE_W-1:0]               wr_be,
  input  logic                          rsv_en,
  input  logic [ADDR_W-1:0]             rsv_addr,
  output logic                          rsv_grant,
  input  logic                          flush,
  output logic [ADDR_W:0]               busy_count
);

  // Storage is padded to a power of two so any address indexes a real entry;
  // entries at or above REG_NUM are never written and never marked busy.
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(REG_NUM);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + {{ADDR_W{1'b0}}, v[i]};
    return n;
  endfunction

  logic [REG_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     busy_next;
  logic                 wr_hit;
  logic [REG_WIDTH-1:0] wr_merged;

  // Write actually lands in storage (register 0 and out-of-range dropped).
  assign wr_hit = wr_en && in_range(wr_addr) && !is_zero(wr_addr);

  // Byte-merge of write data over the stored value; shared by the write and
  // the bypass path so both see identical results.
  always_comb begin
    wr_merged = regs[wr_addr];
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be[b]) wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  // A busy register may be re-reserved in the cycle its writeback arrives.
  assign rsv_grant = rsv_en && !flush && in_range(rsv_addr) &&
                     (!busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));

  // Reservation set is applied after the write clear so it wins on collision.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_en) busy_next[wr_addr] = 1'b0;
      if (rsv_grant && !is_zero(rsv_addr)) busy_next[rsv_addr] = 1'b1;
    end
    for (int i = REG_NUM; i < DEPTH; i++) busy_next[i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_hit) regs[wr_addr] <= wr_merged;
      busy       <= busy_next;
      busy_count <= popcount(busy_next);
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_READ; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              valid;
      logic              zero;
      logic              fwd;

      assign ra    = rd_addr[k*ADDR_W +: ADDR_W];
      assign valid = in_range(ra);
      assign zero  = is_zero(ra);
      assign fwd   = (BYPASS != 0) && wr_hit && (wr_addr == ra);

      assign rd_data[k*REG_WIDTH +: REG_WIDTH] =
        (!valid || zero) ? '0 : (fwd ? wr_merged : regs[ra]);
      assign rd_ready[k] = valid && (zero || fwd || !busy[ra]);
    end
  endgenerate

endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb/tb_scoreboard_register_file.sv - self-checking bench for scoreboard_register_file
module tb_scoreboard_register_file;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_grant;
  logic        flush;
  logic [5:0]  busy_count;

  // Second instance: non-power-of-two size, no zero register, no bypass.
  logic        s_rst;
  logic [2:0]  s_rd_addr;
  logic [15:0] s_rd_data;
  logic [0:0]  s_rd_ready;
  logic        s_wr_en;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic [1:0]  s_wr_be;
  logic        s_rsv_en;
  logic [2:0]  s_rsv_addr;
  logic        s_rsv_grant;
  logic        s_flush;
  logic [3:0]  s_busy_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  scoreboard_register_file dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_grant(rsv_grant),
    .flush(flush), .busy_count(busy_count)
  );

  scoreboard_register_file #(
    .REG_NUM(6), .REG_WIDTH(16), .NUM_READ(1), .ZERO_REG(0), .BYPASS(0)
  ) dut2 (
    .clk(clk), .rst(s_rst), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_ready(s_rd_ready),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_be(s_wr_be),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .rsv_grant(s_rsv_grant),
    .flush(s_flush), .busy_count(s_busy_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic exp_grant();
    return rsv_en && !flush && (!m_busy[rsv_addr] || (wr_en && wr_addr == rsv_addr));
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wr_en && wr_addr == a) return merge(m_regs[a], wr_data, wr_be);
    return m_regs[a];
  endfunction

  function automatic logic exp_ready(input logic [4:0] a);
    if (a == 0) return 1'b1;
    if (wr_en && wr_addr == a) return 1'b1;
    return !m_busy[a];
  endfunction

  function automatic int exp_count();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic void model_edge();
    logic g;
    g = exp_grant();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_busy = 32'h0;
    end else begin
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = merge(m_regs[wr_addr], wr_data, wr_be);
      if (flush) m_busy = 32'h0;
      else begin
        if (wr_en) m_busy[wr_addr] = 1'b0;
        if (g && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    rsv_en = 0; rsv_addr = 0; flush = 0; rd_addr = 0;
  endtask

  function automatic logic [4:0] pick();
    int v;
    v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
    return v[4:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst = 1; wr_en = 1; wr_addr = 5; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rsv_en = 1; rsv_addr = 5; flush = 1;
    tick();
    idle();
    n_cmp++;
    if (busy_count !== 6'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", busy_count); end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      n_cmp++;
      if (rd_data !== 64'h0) begin n_bad++; $display("FAIL reset_data a=%0d got %h exp 0", a, rd_data); end
      n_cmp++;
      if (rd_ready !== 2'b11) begin n_bad++; $display("FAIL reset_ready a=%0d got %b exp 11", a, rd_ready); end
    end
  endtask

  task automatic test_byte_enable();
    idle();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF; wr_be = 4'b1111;
    tick();
    wr_data = 32'h0000_1234; wr_be = 4'b0011;
    tick();
    idle();
    rd_addr = {5'd0, 5'd5};
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'hDEAD_1234) begin n_bad++; $display("FAIL byte_enable got %h exp DEAD1234", rd_data[31:0]); end
  endtask

  task automatic test_reserve();
    idle();
    rsv_en = 1; rsv_addr = 7; rd_addr = {5'd0, 5'd7};
    #1;
    n_cmp++;
    if (rsv_grant !== 1'b1) begin n_bad++; $display("FAIL rsv_first got %b exp 1", rsv_grant); end
    tick();
    n_cmp++;
    if (busy_count !== 6'd1) begin n_bad++; $display("FAIL rsv_count got %0d exp 1", busy_count); end
    n_cmp++;
    if (rd_ready[0] !== 1'b0) begin n_bad++; $display("FAIL rsv_ready got %b exp 0", rd_ready[0]); end
    n_cmp++;
    if (rsv_grant !== 1'b0) begin n_bad++; $display("FAIL rsv_again got %b exp 0", rsv_grant); end
    tick();
    rsv_en = 0; wr_en = 1; wr_addr = 7; wr_data = 32'h55; wr_be = 4'hF;
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h55) begin n_bad++; $display("FAIL bypass_data got %h exp 55", rd_data[31:0]); end
    n_cmp++;
    if (rd_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bypass_ready got %b exp 1", rd_ready[0]); end
    tick();
    idle();
    n_cmp++;
    if (busy_count !== 6'd0) begin n_bad++; $display("FAIL wb_count got %0d exp 0", busy_count); end
  endtask

  task automatic test_rsv_write_same();
    idle();
    rsv_en = 1; rsv_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'hA5A5_5A5A; wr_be = 4'hF;
    #1;
    n_cmp++;
    if (rsv_grant !== 1'b1) begin n_bad++; $display("FAIL same_grant got %b exp 1", rsv_grant); end
    tick();
    idle();
    rd_addr = {5'd3, 5'd0};
    #1;
    n_cmp++;
    if (busy_count !== 6'd1) begin n_bad++; $display("FAIL same_count got %0d exp 1", busy_count); end
    n_cmp++;
    if (rd_ready[1] !== 1'b0) begin n_bad++; $display("FAIL same_ready got %b exp 0", rd_ready[1]); end
    n_cmp++;
    if (rd_data[63:32] !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL same_data got %h exp A5A55A5A", rd_data[63:32]); end
  endtask

  task automatic test_flush();
    logic [4:0] addrs [3];
    addrs[0] = 1; addrs[1] = 2; addrs[2] = 4;
    idle(); rst = 1; tick(); idle();
    for (int i = 0; i < 3; i++) begin
      rsv_en = 1; rsv_addr = addrs[i];
      tick();
      n_cmp++;
      if (busy_count !== 6'(i + 1)) begin n_bad++; $display("FAIL flush_fill got %0d exp %0d", busy_count, i + 1); end
    end
    rsv_addr = 6; flush = 1;
    #1;
    n_cmp++;
    if (rsv_grant !== 1'b0) begin n_bad++; $display("FAIL flush_grant got %b exp 0", rsv_grant); end
    tick();
    idle();
    rd_addr = {5'd6, 5'd1};
    #1;
    n_cmp++;
    if (busy_count !== 6'd0) begin n_bad++; $display("FAIL flush_count got %0d exp 0", busy_count); end
    n_cmp++;
    if (rd_ready !== 2'b11) begin n_bad++; $display("FAIL flush_ready got %b exp 11", rd_ready); end
  endtask

  task automatic test_zero_reg();
    idle();
    rsv_en = 1; rsv_addr = 9;
    tick();
    rsv_addr = 0; wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_addr = {5'd0, 5'd0};
    #1;
    n_cmp++;
    if (rsv_grant !== 1'b1) begin n_bad++; $display("FAIL zero_grant got %b exp 1", rsv_grant); end
    n_cmp++;
    if (rd_data !== 64'h0 || rd_ready !== 2'b11) begin
      n_bad++; $display("FAIL zero_bypass got %h/%b exp 0/11", rd_data, rd_ready);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (busy_count !== 6'd1) begin n_bad++; $display("FAIL zero_count got %0d exp 1", busy_count); end
    n_cmp++;
    if (rd_data !== 64'h0 || rd_ready !== 2'b11) begin
      n_bad++; $display("FAIL zero_read got %h/%b exp 0/11", rd_data, rd_ready);
    end
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = pick();
      wr_data  = $urandom;
      wr_be    = 4'($urandom_range(0, 15));
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = pick();
      flush    = ($urandom_range(0, 24) == 0);
      rd_addr  = {pick(), pick()};
      #1;
      n_cmp++;
      if (rsv_grant !== exp_grant()) begin
        n_bad++; $display("FAIL rand_grant c=%0d got %b exp %b", c, rsv_grant, exp_grant());
      end
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        a = rd_addr[p*5 +: 5];
        n_cmp++;
        if (rd_data[p*32 +: 32] !== exp_data(a)) begin
          n_bad++; $display("FAIL rand_data c=%0d p=%0d got %h exp %h", c, p, rd_data[p*32 +: 32], exp_data(a));
        end
        n_cmp++;
        if (rd_ready[p] !== exp_ready(a)) begin
          n_bad++; $display("FAIL rand_ready c=%0d p=%0d got %b exp %b", c, p, rd_ready[p], exp_ready(a));
        end
      end
      tick();
      n_cmp++;
      if (busy_count !== 6'(exp_count())) begin
        n_bad++; $display("FAIL rand_count c=%0d got %0d exp %0d", c, busy_count, exp_count());
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    wr_en = 1; wr_addr = 10; wr_data = 32'h1357_9BDF; wr_be = 4'hF; rsv_en = 1; rsv_addr = 12;
    tick();
    rsv_addr = 10; wr_en = 0;
    tick();
    rst = 1; rsv_en = 1; rsv_addr = 13; wr_en = 1; wr_addr = 11; wr_data = 32'hFFFF_FFFF;
    tick();
    idle();
    rd_addr = {5'd11, 5'd10};
    #1;
    n_cmp++;
    if (busy_count !== 6'd0) begin n_bad++; $display("FAIL midrst_count got %0d exp 0", busy_count); end
    n_cmp++;
    if (rd_data !== 64'h0 || rd_ready !== 2'b11) begin
      n_bad++; $display("FAIL midrst_read got %h/%b exp 0/11", rd_data, rd_ready);
    end
  endtask

  task automatic test_small_config();
    s_rst = 1; tick(); s_rst = 0;
    for (int a = 6; a < 8; a++) begin
      s_rd_addr = 3'(a);
      #1;
      n_cmp++;
      if (s_rd_data !== 16'h0 || s_rd_ready !== 1'b0) begin
        n_bad++; $display("FAIL oor_read a=%0d got %h/%b exp 0/0", a, s_rd_data, s_rd_ready);
      end
    end
    s_rd_addr = 0; s_wr_en = 1; s_wr_addr = 0; s_wr_data = 16'hBEEF; s_wr_be = 2'b11;
    #1;
    n_cmp++;
    if (s_rd_data !== 16'h0 || s_rd_ready !== 1'b1) begin
      n_bad++; $display("FAIL nobypass_r0 got %h/%b exp 0/1", s_rd_data, s_rd_ready);
    end
    tick();
    s_wr_en = 0;
    #1;
    n_cmp++;
    if (s_rd_data !== 16'hBEEF) begin n_bad++; $display("FAIL r0_write got %h exp BEEF", s_rd_data); end
    s_wr_en = 1; s_wr_addr = 6; s_wr_data = 16'h1111; s_rsv_en = 1; s_rsv_addr = 7;
    #1;
    n_cmp++;
    if (s_rsv_grant !== 1'b0) begin n_bad++; $display("FAIL oor_grant got %b exp 0", s_rsv_grant); end
    tick();
    s_wr_en = 0; s_rsv_en = 0; s_rd_addr = 6;
    #1;
    n_cmp++;
    if (s_busy_count !== 4'd0 || s_rd_data !== 16'h0) begin
      n_bad++; $display("FAIL oor_ignored got %0d/%h exp 0/0", s_busy_count, s_rd_data);
    end
    s_rsv_en = 1; s_rsv_addr = 5; s_rd_addr = 5;
    #1;
    n_cmp++;
    if (s_rsv_grant !== 1'b1) begin n_bad++; $display("FAIL small_grant got %b exp 1", s_rsv_grant); end
    tick();
    s_rsv_en = 0; s_wr_en = 1; s_wr_addr = 5; s_wr_data = 16'h0022; s_wr_be = 2'b11;
    #1;
    n_cmp++;
    if (s_rd_ready !== 1'b0 || s_rd_data !== 16'h0) begin
      n_bad++; $display("FAIL nobypass_busy got %h/%b exp 0/0", s_rd_data, s_rd_ready);
    end
    n_cmp++;
    if (s_busy_count !== 4'd1) begin n_bad++; $display("FAIL small_count got %0d exp 1", s_busy_count); end
    tick();
    s_wr_en = 0;
    #1;
    n_cmp++;
    if (s_rd_ready !== 1'b1 || s_rd_data !== 16'h0022 || s_busy_count !== 4'd0) begin
      n_bad++; $display("FAIL small_wb got %h/%b/%0d exp 0022/1/0", s_rd_data, s_rd_ready, s_busy_count);
    end
    s_rsv_en = 1; s_rsv_addr = 0;
    #1;
    n_cmp++;
    if (s_rsv_grant !== 1'b1) begin n_bad++; $display("FAIL r0_rsv_grant got %b exp 1", s_rsv_grant); end
    tick();
    s_rsv_en = 0;
    #1;
    n_cmp++;
    if (s_busy_count !== 4'd1) begin n_bad++; $display("FAIL r0_rsv_count got %0d exp 1", s_busy_count); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_busy = 32'h0;
    idle();
    s_rst = 0; s_rd_addr = 0; s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_wr_be = 0;
    s_rsv_en = 0; s_rsv_addr = 0; s_flush = 0;
    test_reset();
    test_byte_enable();
    test_reserve();
    test_rsv_write_same();
    test_flush();
    test_zero_reg();
    test_random();
    test_reset_mid();
    test_small_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
